// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with registered read data, status flags, sticky errors and flush
module sync_fifo_buf #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          dout,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       flush,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              wr_acc, rd_acc;

    // Flags come from the registered count; flush blocks any transfer in its cycle
    always_comb begin
        full         = count == CW'(DEPTH);
        empty        = count == '0;
        almost_full  = count >= CW'(AF_LEVEL);
        almost_empty = count <= CW'(AE_LEVEL);
        wr_acc       = wr_en & ~full & ~flush;
        rd_acc       = rd_en & ~empty & ~flush;
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= din;
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) dout <= mem[rptr];
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + 1'b1;
                if (rd_acc) rptr <= rptr + 1'b1;
                count <= count + CW'(wr_acc) - CW'(rd_acc);
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear, flush cycles log nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full & ~flush) | (overflow & ~clr_err);
            underflow <= (rd_en & empty & ~flush) | (underflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb_sync_fifo_buf: directed self-checking bench for sync_fifo_buf
module tb_sync_fifo_buf;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [7:0] din = '0, dout;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         tests = 0, fails = 0;

    sync_fifo_buf dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .flush(flush), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        wr_en = 1'b1;
        din   = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] v);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk({tag, "_dout"}, 32'(dout), 32'(v));
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_err", {30'd0, overflow, underflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        push(8'hA5);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_count", 32'(count), 1);
        pop_chk("t1", 8'hA5);
        chk("t1_count0", 32'(count), 0);
        chk("t1_empty1", 32'(empty), 1);
        step();
        chk("t1_valid_drop", 32'(rd_valid), 0);
        chk("t1_hold", 32'(dout), 32'hA5);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
        end
        chk("fill_full", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            pop_chk("drain", 8'(i));
            chk("drain_ae", 32'(almost_empty), 32'(15 - i <= 2));
        end
        chk("drain_empty", 32'(empty), 1);

        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 10; i++) pop_chk("wrap_a", 8'(8'h10 + i));
        for (int i = 0; i < 12; i++) push(8'(8'h20 + i));
        chk("wrap_count12", 32'(count), 12);
        for (int i = 0; i < 12; i++) begin
            pop_chk("wrap_b", 8'(8'h20 + i));
            chk("wrap_count", 32'(count), 32'(11 - i));
        end

        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h45;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw5_count", 32'(count), 5);
        chk("rw5_dout", 32'(dout), 32'h40);
        for (int i = 1; i < 6; i++) pop_chk("rw5_order", 8'(8'h40 + i));

        for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rwf_count", 32'(count), 15);
        chk("rwf_ovf", 32'(overflow), 1);
        chk("rwf_dout", 32'(dout), 32'h50);
        for (int i = 1; i < 16; i++) pop_chk("rwf_order", 8'(8'h50 + i));
        chk("rwf_empty", 32'(empty), 1);

        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rwe_count", 32'(count), 1);
        chk("rwe_udf", 32'(underflow), 1);
        chk("rwe_valid", 32'(rd_valid), 0);
        chk("rwe_hold", 32'(dout), 32'h5F);

        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udf", 32'(underflow), 0);

        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("pre_flush_count", 32'(count), 6);
        flush = 1'b1; wr_en = 1'b1; din = 8'h99;
        step();
        flush = 1'b0; wr_en = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_dout", 32'(dout), 32'h5F);
        chk("flush_valid", 32'(rd_valid), 0);

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("udf_again", 32'(underflow), 1);
        rd_en = 1'b1; clr_err = 1'b1;
        step();
        rd_en = 1'b0; clr_err = 1'b0;
        chk("set_wins", 32'(underflow), 1);

        push(8'h3C);
        chk("int_count", 32'(count), 1);
        pop_chk("int", 8'h3C);
        chk("int_empty", 32'(empty), 1);
        step();
        chk("int_stable", 32'(dout), 32'h3C);

        for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_udf", 32'(underflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
